seq_multiply: RTL and testbench

//   Sequential signed two's-complement multiplier. Companion to the ALU divide

---
 rtl/seq_multiply.sv | 159 +++++++++++++++
 tb/tb_seq_multiply.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiply.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes, one bit
// per clock, followed by a single sign fix-up cycle and a one-cycle done pulse.
module seq_multiply #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     M,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        if (x[WIDTH-1]) begin
            m = {WIDTH{1'b0}} - x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [2*WIDTH-1:0]   mag_q_r;
    logic [WIDTH-1:0]     mag_m_r;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     count_r;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;
    logic [WIDTH-1:0]     result_r;
    logic                 ovf_r;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH:0]       top_bits_s;
    logic                 ovf_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sign fix-up and overflow detect; negating zero yields zero.
    always_comb begin
        product_s  = {2*WIDTH{1'b0}};
        top_bits_s = {(WIDTH+1){1'b0}};
        ovf_s      = 1'b0;
        if (neg_r) begin
            product_s = {2*WIDTH{1'b0}} - acc_r;
        end else begin
            product_s = acc_r;
        end
        top_bits_s = product_s[2*WIDTH-1:WIDTH-1];
        ovf_s      = ~((&top_bits_s) | (~|top_bits_s));
    end

    // Datapath and registered outputs; done is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q_r   <= {2*WIDTH{1'b0}};
            mag_m_r   <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            acc_r     <= {2*WIDTH{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {2*WIDTH{1'b0}};
            result_r  <= {WIDTH{1'b0}};
            ovf_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mag_q_r <= {{WIDTH{1'b0}}, magnitude(Q)};
                        mag_m_r <= magnitude(M);
                        neg_r   <= Q[WIDTH-1] ^ M[WIDTH-1];
                        acc_r   <= {2*WIDTH{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    // mag_q_r is pre-shifted, so it always equals |Q| << count.
                    if (mag_m_r[0]) begin
                        acc_r <= acc_r + mag_q_r;
                    end
                    mag_q_r <= mag_q_r << 1;
                    mag_m_r <= mag_m_r >> 1;
                    count_r <= count_r + CNT_ONE;
                    busy_r  <= 1'b1;
                end
                FIX: begin
                    product_r <= product_s;
                    result_r  <= product_s[WIDTH-1:0];
                    ovf_r     <= ovf_s;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign result  = result_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_seq_multiply.sv
// Self-checking bench for seq_multiply: directed vector table, handshake corner
// sequences, and a randomized pass against a signed reference product.
module tb_seq_multiply;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] Q;
    logic [15:0] M;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] result;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    seq_multiply #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .Q(Q), .M(M),
        .busy(busy), .done(done), .product(product), .result(result), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] m;
        logic [31:0] p;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Launch one op at a negedge and wait for done; lat counts clocks after the accepting edge.
    task automatic run_op(input logic [15:0] q, input logic [15:0] m,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; Q = q; M = m;
        @(negedge clk);
        start = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t        vecs[10];
    int          lat;
    int          ndone;
    logic        bok;
    logic [15:0] q2;
    logic [15:0] m2;
    logic signed [31:0] ref_p;

    initial begin
        vecs[0] = '{16'h0007, 16'hFFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 32'h4000_0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h0001, 32'hFFFF_8000, 1'b0};
        vecs[3] = '{16'd300,  16'd300,  32'h0001_5F90, 1'b1};
        vecs[4] = '{16'h0000, 16'hFFFB, 32'h0000_0000, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b1};
        vecs[7] = '{16'h8000, 16'hFFFF, 32'h0000_8000, 1'b1};
        vecs[8] = '{16'd100,  16'hFF38, 32'hFFFF_B1E0, 1'b0};
        vecs[9] = '{16'hFFFB, 16'h0000, 32'h0000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; Q = 16'h0; M = 16'h0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_product", product, 32'd0);
        check("reset_ovf", {31'b0, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].q, vecs[i].m, lat, bok);
            check($sformatf("vec%0d_latency", i), lat, 32'd17);
            check($sformatf("vec%0d_busy", i), {31'b0, bok}, 32'd1);
            check($sformatf("vec%0d_product", i), product, vecs[i].p);
            check($sformatf("vec%0d_result", i), {16'b0, result}, {16'b0, vecs[i].p[15:0]});
            check($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].o});
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
            check($sformatf("vec%0d_hold", i), product, vecs[i].p);
        end

        // start held and operands toggled during RUN: one done from first operands.
        @(negedge clk);
        start = 1'b1; Q = 16'd12; M = 16'hFFF9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            Q = 16'($urandom); M = 16'($urandom);
        end
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("held_start_product", product, 32'hFFFF_FFAC);
            end
        end
        check("held_start_done_count", ndone, 32'd1);

        // start in the done cycle is accepted; second done 18 clocks later.
        run_op(16'd5, 16'd6, lat, bok);
        check("b2b_first_product", product, 32'd30);
        start = 1'b1; Q = 16'hFFFE; M = 16'd9;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_spacing", lat, 32'd18);
        check("b2b_second_product", product, 32'hFFFF_FFEE);

        // Reset mid-RUN aborts with no done and zeroed outputs.
        @(negedge clk);
        start = 1'b1; Q = 16'd1234; M = 16'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_product", product, 32'd0);
        check("midrst_result", {16'b0, result}, 32'd0);
        check("midrst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 32'd0);
        run_op(16'd1234, 16'd77, lat, bok);
        check("post_rst_latency", lat, 32'd17);
        check("post_rst_product", product, 32'd95018);

        // Random signed operands against the reference product.
        for (int i = 0; i < 600; i++) begin
            q2 = 16'($urandom);
            m2 = 16'($urandom);
            if (i % 7 == 0) q2 = 16'h8000;
            ref_p = $signed(q2) * $signed(m2);
            run_op(q2, m2, lat, bok);
            check("rand_latency", lat, 32'd17);
            check("rand_busy", {31'b0, bok}, 32'd1);
            check("rand_product", product, ref_p);
            check("rand_ovf", {31'b0, ovf},
                  {31'b0, (ref_p > 32'sd32767) || (ref_p < -32'sd32768)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
